// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: word size, the NOP used as the idle instruction,
// the fetch FSM state encoding and the instruction buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode. The head entry is read straight
// from the storage registers, so decode never sees memory read data combinationally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is accepted when the head leaves in the same cycle.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '{instr: NOP_INSTR, pc: '0};
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, buffered hand-off to decode,
// redirect handling. FETCH_MISALIGN_CHECK_EN adds the fetch_fault port and check.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  redirect_tgt;
    logic             halted;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (redirect_valid) begin
            fault <= |redirect_pc[1:0];
        end
    end

    always_comb begin
        redirect_tgt = redirect_pc;
        halted       = fault;
        fetch_fault  = fault;
    end
`else
    always_comb begin
        redirect_tgt = align_pc(redirect_pc);
        halted       = 1'b0;
    end
`endif

    // Outstanding count is always zero in FETCH, so occupancy alone bounds the request.
    always_comb begin
        imem_req   = (state == FETCH) && (fifo_count < CNT_W'(FIFO_DEPTH)) && !halted;
        imem_addr  = pc;
        fifo_push  = (state == WAIT) && imem_rvalid && !redirect_valid && !fifo_full;
        fifo_pop   = id_ready;
        fifo_wdata = '{instr: imem_rdata, pc: req_pc};
        id_valid   = !fifo_empty;
        id_instr   = fifo_head.instr;
        id_pc      = fifo_head.pc;
    end

    // A redirect that lands on an accepted request still owes one response, hence DROP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect_valid) pc <= redirect_tgt;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= imem_req ? DROP : FETCH;
                    end else if (imem_req) begin
                        req_pc <= pc;
                        pc     <= pc + XLEN'(4);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (imem_rvalid) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(redirect_valid),
        .wdata(fifo_wdata),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule
